// File: rtl/fpu_exp_pkg.sv
// ---------------------------------------------------------------------------
// fpu_exp_pkg
// Shared definitions for the FP add/sub exponent handling:
//   - exponent widths for single and double precision (carry MSB included)
//   - derived exponent limits u_lim()/l_lim()
//   - two-state occupancy type of the single-entry result register
// ---------------------------------------------------------------------------
package fpu_exp_pkg;

    localparam int W_EXP_SP = 32'sd9;
    localparam int W_EXP_DP = 32'sd12;

    // Occupancy of the result register: EMPTY until an exponent is accepted.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } xfer_state_t;

    // Largest normal exponent: the all-ones field is reserved for Inf/NaN.
    function automatic int u_lim(input int w);
        return (32'sd1 <<< (w - 32'sd1)) - 32'sd2;
    endfunction

    // Smallest normal exponent; an exponent field of zero is denormal/zero.
    // A width of one bit leaves no room for a normal range at all.
    function automatic int l_lim(input int w);
        return (w > 32'sd1) ? 32'sd1 : 32'sd0;
    endfunction

endpackage : fpu_exp_pkg

// File: rtl/exp_limit_cmp.sv
// ---------------------------------------------------------------------------
// exp_limit_cmp
// Purely combinational classification of a post-normalisation exponent.
// Ports:
//   exp          in  W_Exp    exponent incl. carry MSB (two's complement if SIGNED_E)
//   ovf          out 1        exponent above the largest normal exponent
//   unf          out 1        exponent below the smallest normal exponent
//   exp_clamped  out W_Exp-1  field saturated to all-ones / zero on ovf / unf
// ---------------------------------------------------------------------------
module exp_limit_cmp
    import fpu_exp_pkg::*;
#(
    parameter int W_Exp    = 9,
    parameter bit SIGNED_E = 1'b0
) (
    input  logic [W_Exp-1:0] exp,
    output logic             ovf,
    output logic             unf,
    output logic [W_Exp-2:0] exp_clamped
);

    localparam logic [W_Exp-1:0] U_LIM = W_Exp'(u_lim(W_Exp));
    localparam logic [W_Exp-1:0] L_LIM = W_Exp'(l_lim(W_Exp));

    // Classify against the limits and build the saturated exponent field.
    always_comb begin
        ovf         = 1'b0;
        unf         = 1'b0;
        exp_clamped = exp[W_Exp-2:0];
        // A set MSB is a negative exponent in signed mode; in unsigned mode it
        // is simply a large value and the compare below flags it as overflow.
        if (SIGNED_E && exp[W_Exp-1]) begin
            unf = 1'b1;
        end else begin
            ovf = (exp > U_LIM);
            unf = (exp < L_LIM);
        end
        if (ovf) begin
            exp_clamped = {(W_Exp-1){1'b1}};
        end else if (unf) begin
            exp_clamped = {(W_Exp-1){1'b0}};
        end else begin
            exp_clamped = exp[W_Exp-2:0];
        end
    end

endmodule : exp_limit_cmp

// File: rtl/exp_range_checker.sv
// ---------------------------------------------------------------------------
// exp_range_checker
// Registered exponent range check between normalisation and packing/rounding.
// One result register with valid/ready flow control (latency 1, full
// throughput), sticky overflow/underflow flags and saturating event counters.
// Ports:
//   clk         in  1        clock, rising edge
//   rst         in  1        asynchronous active-low reset
//   in_valid    in  1        exp valid this cycle
//   in_ready    out 1        block can accept exp
//   exp         in  W_Exp    exponent from normalisation
//   out_valid   out 1        result registers hold a valid result
//   out_ready   in  1        downstream accepts result
//   exp_out     out W_Exp-1  checked / clamped exponent field
//   overflow    out 1        result exponent above upper limit
//   underflow   out 1        result exponent below lower limit
//   clr_flags   in  1        synchronous clear of stickies and counters
//   ovf_sticky  out 1        overflow seen since last clear
//   unf_sticky  out 1        underflow seen since last clear
//   ovf_cnt     out CNT_W    accepted overflows, saturating
//   unf_cnt     out CNT_W    accepted underflows, saturating
// ---------------------------------------------------------------------------
module exp_range_checker
    import fpu_exp_pkg::*;
#(
    parameter int W_Exp    = 9,
    parameter bit SIGNED_E = 1'b0,
    parameter bit SAT_EN   = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_Exp-1:0] exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_Exp-2:0] exp_out,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_flags,
    output logic             ovf_sticky,
    output logic             unf_sticky,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] unf_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    xfer_state_t      r_state;
    xfer_state_t      w_state_next;
    logic             w_accept;
    logic             w_ovf;
    logic             w_unf;
    logic [W_Exp-2:0] w_clamped;
    logic [W_Exp-2:0] w_exp_sel;

    logic             r_ovf;
    logic             r_unf;
    logic [W_Exp-2:0] r_exp_out;
    logic             r_ovs;
    logic             r_uns;
    logic [CNT_W-1:0] r_ovc;
    logic [CNT_W-1:0] r_unc;
    logic             w_ovs_next;
    logic             w_uns_next;
    logic [CNT_W-1:0] w_ovc_next;
    logic [CNT_W-1:0] w_unc_next;

    exp_limit_cmp #(
        .W_Exp    (W_Exp),
        .SIGNED_E (SIGNED_E)
    ) u_cmp (
        .exp         (exp),
        .ovf         (w_ovf),
        .unf         (w_unf),
        .exp_clamped (w_clamped)
    );

    assign w_exp_sel = SAT_EN ? w_clamped : exp[W_Exp-2:0];
    // A full register can take a new exponent in the same cycle it drains.
    assign in_ready  = (r_state == ST_EMPTY) | out_ready;
    assign w_accept  = in_valid & in_ready;

    // Occupancy next state: fill on accept, empty on a drain without refill.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                end else if (out_ready) begin
                    w_state_next = ST_EMPTY;
                end else begin
                    w_state_next = ST_FULL;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result register: loads only on accept so a stalled result stays put.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp_out <= {(W_Exp-1){1'b0}};
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else if (w_accept) begin
            r_exp_out <= w_exp_sel;
            r_ovf     <= w_ovf;
            r_unf     <= w_unf;
        end else begin
            r_exp_out <= r_exp_out;
            r_ovf     <= r_ovf;
            r_unf     <= r_unf;
        end
    end

    // Sticky/counter next values; an accepted event takes priority over a clear.
    always_comb begin
        w_ovs_next = r_ovs;
        w_ovc_next = r_ovc;
        w_uns_next = r_uns;
        w_unc_next = r_unc;
        if (w_accept && w_ovf) begin
            w_ovs_next = 1'b1;
            w_ovc_next = clr_flags ? CNT_W'(1'b1) : sat_inc(r_ovc);
        end else if (clr_flags) begin
            w_ovs_next = 1'b0;
            w_ovc_next = {CNT_W{1'b0}};
        end else begin
            w_ovs_next = r_ovs;
            w_ovc_next = r_ovc;
        end
        if (w_accept && w_unf) begin
            w_uns_next = 1'b1;
            w_unc_next = clr_flags ? CNT_W'(1'b1) : sat_inc(r_unc);
        end else if (clr_flags) begin
            w_uns_next = 1'b0;
            w_unc_next = {CNT_W{1'b0}};
        end else begin
            w_uns_next = r_uns;
            w_unc_next = r_unc;
        end
    end

    // Sticky flags and event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovs <= 1'b0;
            r_uns <= 1'b0;
            r_ovc <= {CNT_W{1'b0}};
            r_unc <= {CNT_W{1'b0}};
        end else begin
            r_ovs <= w_ovs_next;
            r_uns <= w_uns_next;
            r_ovc <= w_ovc_next;
            r_unc <= w_unc_next;
        end
    end

    assign out_valid  = (r_state == ST_FULL);
    assign exp_out    = r_exp_out;
    assign overflow   = r_ovf;
    assign underflow  = r_unf;
    assign ovf_sticky = r_ovs;
    assign unf_sticky = r_uns;
    assign ovf_cnt    = r_ovc;
    assign unf_cnt    = r_unc;

endmodule : exp_range_checker
